// File: rtl/score_playback_scheduler_pkg.sv
// Shared state encoding and score ROM entry layout {length, note, octave}
// for the score playback scheduler.
package score_playback_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PLAY,
        ST_GAP,
        ST_PAUSE,
        ST_DONE
    } state_e;

    localparam int EOF_NOTE_CODE = 15;

    localparam int OCT_LSB  = 0;
    localparam int OCT_MSB  = 3;
    localparam int NOTE_LSB = 4;
    localparam int NOTE_MSB = 7;
    localparam int LEN_LSB  = 8;
    localparam int LEN_MSB  = 23;

    // Length field MSB for a build with a non-default length width.
    function automatic int len_msb(input int len_w);
        return LEN_LSB + len_w - 1;
    endfunction

endpackage

// File: rtl/score_playback_scheduler_note_timer.sv
// Sound/gap down-counter pair: splits a note length into a sounding part and
// a trailing silent gap, then counts each part down while not frozen.
module score_playback_scheduler_note_timer #(
    parameter int LEN_W  = 16,
    parameter int GAP_MS = 20
) (
    input  logic             clk_1ms,
    input  logic             rst,
    input  logic             load_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             run_i,
    input  logic             freeze_i,
    input  logic             sel_gap_i,
    output logic             snd_last_o,
    output logic             gap_zero_o,
    output logic             gap_last_o
);

    localparam logic [LEN_W-1:0] GAP = LEN_W'(GAP_MS);
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    logic [LEN_W-1:0] snd_q, snd_d;
    logic [LEN_W-1:0] gap_q, gap_d;

    always_comb begin
        snd_d = snd_q;
        gap_d = gap_q;
        if (load_i) begin
            // Short notes get no gap so they still sound for their full length.
            if (len_i > GAP) begin
                snd_d = len_i - GAP;
                gap_d = GAP;
            end else begin
                snd_d = len_i;
                gap_d = '0;
            end
        end else if (run_i && !freeze_i) begin
            if (sel_gap_i) gap_d = gap_q - ONE;
            else           snd_d = snd_q - ONE;
        end
    end

    always_ff @(posedge clk_1ms) begin
        if (rst) begin
            snd_q <= '0;
            gap_q <= '0;
        end else begin
            snd_q <= snd_d;
            gap_q <= gap_d;
        end
    end

    assign snd_last_o = (snd_q == ONE);
    assign gap_zero_o = (gap_q == '0);
    assign gap_last_o = (gap_q == ONE);

endmodule

// File: rtl/score_playback_scheduler.sv
// Song playback sequencer: walks score ROM entries, times notes and gaps,
// handles play/pause/stop. Define SCORE_LOOP_EN to loop the song on EOF.
module score_playback_scheduler
    import score_playback_scheduler_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int LEN_W    = 16,
    parameter int EOF_NOTE = EOF_NOTE_CODE,
    parameter int GAP_MS   = 20
) (
    input  logic              clk_1ms,
    input  logic              rst,
    input  logic              play,
    input  logic              stop,
    input  logic              pause,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [LEN_W+7:0]  rom_data,
    output logic [3:0]        cur_note,
    output logic [3:0]        cur_octave,
    output logic              note_valid,
    output logic              note_start,
    output logic              busy,
    output logic              done,
    output logic [15:0]       elapsed_ms
);

    localparam int LMSB = len_msb(LEN_W);

    state_e state_q, state_d;
    state_e ret_q, ret_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        note_q, note_d;
    logic [3:0]        oct_q, oct_d;
    logic              nstart_q, nstart_d;
    logic              done_q, done_d;
    logic [15:0]       elapsed_q, elapsed_d;
`ifdef SCORE_LOOP_EN
    logic [ADDR_W-1:0] start_q, start_d;
`endif

    logic [LEN_W-1:0] f_len;
    logic [3:0]       f_note;
    logic [3:0]       f_oct;
    logic             f_eof;
    logic             f_skip;
    logic             tmr_load;
    logic             snd_last;
    logic             gap_zero;
    logic             gap_last;

    assign f_len  = rom_data[LMSB:LEN_LSB];
    assign f_note = rom_data[NOTE_MSB:NOTE_LSB];
    assign f_oct  = rom_data[OCT_MSB:OCT_LSB];
    assign f_eof  = (f_note == 4'(EOF_NOTE));
    assign f_skip = (f_len == '0);

    assign tmr_load = (state_q == ST_FETCH) && !stop && !f_eof && !f_skip;

    score_playback_scheduler_note_timer #(
        .LEN_W  (LEN_W),
        .GAP_MS (GAP_MS)
    ) u_timer (
        .clk_1ms    (clk_1ms),
        .rst        (rst),
        .load_i     (tmr_load),
        .len_i      (f_len),
        .run_i      ((state_q == ST_PLAY || state_q == ST_GAP) && !stop),
        .freeze_i   (pause),
        .sel_gap_i  (state_q == ST_GAP),
        .snd_last_o (snd_last),
        .gap_zero_o (gap_zero),
        .gap_last_o (gap_last)
    );

    always_ff @(posedge clk_1ms) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ret_q   <= ST_PLAY;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (play) state_d = ST_FETCH;
                ST_FETCH: begin
                    if (f_eof) begin
`ifdef SCORE_LOOP_EN
                        state_d = ST_FETCH;
`else
                        state_d = ST_DONE;
`endif
                    end else if (!f_skip) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (pause) begin
                        ret_d   = ST_PLAY;
                        state_d = ST_PAUSE;
                    end else if (snd_last) begin
                        state_d = gap_zero ? ST_FETCH : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (pause) begin
                        ret_d   = ST_GAP;
                        state_d = ST_PAUSE;
                    end else if (gap_last) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_PAUSE: if (!pause) state_d = ret_q;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        note_valid = (state_q == ST_PLAY);
        busy       = (state_q == ST_FETCH) || (state_q == ST_PLAY) ||
                     (state_q == ST_GAP)   || (state_q == ST_PAUSE);
    end

    // Address, latched note and elapsed time; stop leaves them all untouched.
    always_comb begin
        addr_d    = addr_q;
        note_d    = note_q;
        oct_d     = oct_q;
        elapsed_d = elapsed_q;
        nstart_d  = 1'b0;
        done_d    = 1'b0;
`ifdef SCORE_LOOP_EN
        start_d   = start_q;
`endif
        if (!stop) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (play) begin
                        addr_d    = start_addr;
                        elapsed_d = '0;
`ifdef SCORE_LOOP_EN
                        start_d   = start_addr;
`endif
                    end
                end
                ST_FETCH: begin
                    if (f_eof) begin
                        done_d = 1'b1;
`ifdef SCORE_LOOP_EN
                        addr_d = start_q;
`endif
                    end else if (f_skip) begin
                        addr_d = addr_q + 1'b1;
                    end else begin
                        note_d   = f_note;
                        oct_d    = f_oct;
                        nstart_d = 1'b1;
                    end
                end
                ST_PLAY, ST_GAP: begin
                    if (!pause) begin
                        if (elapsed_q != 16'hFFFF) elapsed_d = elapsed_q + 16'd1;
                        if ((state_q == ST_PLAY && snd_last && gap_zero) ||
                            (state_q == ST_GAP && gap_last))
                            addr_d = addr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_1ms) begin
        if (rst) begin
            addr_q    <= '0;
            note_q    <= '0;
            oct_q     <= '0;
            nstart_q  <= 1'b0;
            done_q    <= 1'b0;
            elapsed_q <= '0;
`ifdef SCORE_LOOP_EN
            start_q   <= '0;
`endif
        end else begin
            addr_q    <= addr_d;
            note_q    <= note_d;
            oct_q     <= oct_d;
            nstart_q  <= nstart_d;
            done_q    <= done_d;
            elapsed_q <= elapsed_d;
`ifdef SCORE_LOOP_EN
            start_q   <= start_d;
`endif
        end
    end

    assign rom_addr   = addr_q;
    assign cur_note   = note_q;
    assign cur_octave = oct_q;
    assign note_start = nstart_q;
    assign done       = done_q;
    assign elapsed_ms = elapsed_q;

endmodule
